// File: rtl/regfile_burst_writer.sv
// rtl/regfile_burst_writer.sv - burst command + data stream to single-cycle register-file writes
// Addresses auto-increment modulo DEPTH; every accepted beat becomes one registered write.
module regfile_burst_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_burst_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [AW-1:0]     r_cur_addr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [DATA_W-1:0] r_out_data;
  logic              r_burst_done;
  logic              w_cmd_hs;
  logic              w_in_hs;
  logic              w_last_beat;

  // Readies come from state alone; reset only masks them so nothing is taken while it is high.
  assign o_cmd_ready = (r_state == S_IDLE) && !reset;
  assign o_in_ready  = (r_state == S_BURST) && !reset;
  assign o_busy      = (r_state == S_BURST) && !reset;

  assign w_cmd_hs    = i_cmd_valid && o_cmd_ready;
  assign w_in_hs     = i_in_valid && o_in_ready;
  assign w_last_beat = (r_remaining == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_hs) w_state_next = S_BURST;
      S_BURST: if (w_in_hs && w_last_beat) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_out_valid  <= w_in_hs;
      r_burst_done <= w_in_hs && w_last_beat;
      if (w_cmd_hs) begin
        r_cur_addr  <= AW'(i_cmd_addr % DEPTH);
        r_remaining <= i_cmd_len;
      end
      if (w_in_hs) begin
        r_out_addr  <= ADDR_W'(r_cur_addr);
        r_out_data  <= i_in_data;
        r_cur_addr  <= r_cur_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_addr   = r_out_addr;
  assign o_out_data   = r_out_data;
  assign o_burst_done = r_burst_done;

endmodule

// File: tb/tb_regfile_burst_writer.sv
// tb/tb_regfile_burst_writer.sv - directed and random bench against a burst-level reference model
module tb_regfile_burst_writer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;
  localparam int LEN_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [ADDR_W-1:0] i_cmd_addr = '0;
  logic [LEN_W-1:0]  i_cmd_len = '0;
  logic              i_in_valid = 1'b0;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data = '0;
  logic              o_out_valid;
  logic [ADDR_W-1:0] o_out_addr;
  logic [DATA_W-1:0] o_out_data;
  logic              o_busy;
  logic              o_burst_done;

  regfile_burst_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_len   (i_cmd_len),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .o_out_addr  (o_out_addr),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy),
    .o_burst_done(o_burst_done)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: a burst is (base, length, beats taken so far); write k goes to (base+k) mod DEPTH.
  bit m_burst = 1'b0;
  int m_base  = 0;
  int m_len   = 0;
  int m_k     = 0;
  bit e_valid = 1'b0;
  bit e_done  = 1'b0;
  int e_addr  = 0;
  int e_data  = 0;
  int n_writes_dut = 0;
  int n_writes_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, check after it.
  task automatic step(input bit rst, input bit cv, input int ca, input int cl,
                      input bit iv, input int id);
    reset       = rst;
    i_cmd_valid = cv;
    i_cmd_addr  = ca[ADDR_W-1:0];
    i_cmd_len   = cl[LEN_W-1:0];
    i_in_valid  = iv;
    i_in_data   = id[DATA_W-1:0];
    #1;
    check("cmd_ready", 32'(o_cmd_ready), 32'(!rst && !m_burst));
    check("in_ready", 32'(o_in_ready), 32'(!rst && m_burst));
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (rst) begin
      m_burst = 1'b0;
    end else if (!m_burst && cv) begin
      m_base  = ca % DEPTH;
      m_len   = cl % (1 << LEN_W);
      m_k     = 0;
      m_burst = 1'b1;
    end else if (m_burst && iv) begin
      e_valid = 1'b1;
      e_addr  = (m_base + m_k) % DEPTH;
      e_data  = id % (1 << DATA_W);
      e_done  = (m_k == m_len);
      m_k++;
      if (e_done) m_burst = 1'b0;
      n_writes_exp++;
    end
    @(posedge clock);
    @(negedge clock);
    if (o_out_valid === 1'b1) n_writes_dut++;
    check("out_valid", 32'(o_out_valid), 32'(e_valid));
    check("burst_done", 32'(o_burst_done), 32'(e_done));
    check("busy", 32'(o_busy), 32'(m_burst));
    if (e_valid) begin
      check("out_addr", 32'(o_out_addr), 32'(e_addr));
      check("out_data", 32'(o_out_data), 32'(e_data));
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic beat(input int d);
    step(1'b0, 1'b0, 0, 0, 1'b1, d);
  endtask

  initial begin
    @(negedge clock);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 3, 1, 1'b1, 8'h99);
    check("rst_out_addr", 32'(o_out_addr), 32'h0);
    check("rst_out_data", 32'(o_out_data), 32'h0);

    // 1: addr 2, four back-to-back beats
    step(1'b0, 1'b1, 2, 3, 1'b0, 0);
    beat(8'hA0); beat(8'hA1); beat(8'hA2); beat(8'hA3);
    idle_step();
    // 2: wrap 7 -> 0
    step(1'b0, 1'b1, 6, 3, 1'b0, 0);
    beat(8'h11); beat(8'h22); beat(8'h33); beat(8'h44);
    // 3: upper address bits dropped, single beat, cmd_ready back next cycle
    step(1'b0, 1'b1, 8'h0D, 0, 1'b0, 0);
    beat(8'h5A);
    idle_step();
    // 4: gaps in the data stream
    step(1'b0, 1'b1, 0, 2, 1'b0, 0);
    beat(8'hC1); idle_step(); idle_step(); beat(8'hC2); beat(8'hC3);
    idle_step();
    // 5: reset after the second of four beats, then a fresh burst
    step(1'b0, 1'b1, 1, 3, 1'b0, 0);
    beat(8'hD1); beat(8'hD2);
    step(1'b1, 1'b0, 0, 0, 1'b1, 8'hD3);
    step(1'b0, 1'b1, 4, 0, 1'b1, 8'hD4);
    beat(8'hE4);
    idle_step();
    // 6: data while idle ignored, command while busy held off
    beat(8'h77); beat(8'h78);
    step(1'b0, 1'b1, 3, 1, 1'b1, 8'h79);
    step(1'b0, 1'b1, 6, 0, 1'b1, 8'hF1);
    step(1'b0, 1'b1, 6, 0, 1'b1, 8'hF2);
    step(1'b0, 1'b1, 6, 0, 1'b0, 0);
    beat(8'hF3);
    idle_step();

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 255)));
    end
    idle_step();
    check("write_count", 32'(n_writes_dut), 32'(n_writes_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
